// File: rtl/fetch_stage_bp.sv
// rtl/fetch_stage_bp.sv - instruction fetch stage with tagless BTB/BHT branch predictor
// Optional predictor enabled by defining BRANCH_PREDICT_EN; default build is static not-taken.
module fetch_stage_bp #(
   parameter int          BTB_ENTRIES = 8,
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [1:0]  CNT_INIT    = 2'b01
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic [15:0] imem_rdata,
   input  logic        upd_en,
   input  logic [3:0]  upd_PC_curr,
   input  logic        upd_taken,
   input  logic [15:0] upd_target,
   input  logic        mispredict,
   input  logic [15:0] redirect_PC,
   output logic [15:0] imem_addr,
   output logic [15:0] PC_curr,
   output logic [15:0] PC_next,
   output logic [15:0] PC_inst,
   output logic        predicted_taken,
   output logic [15:0] predicted_target
);

   logic [15:0] pc;
   logic [15:0] pc_d;
   logic        halt;

   assign imem_addr = pc;
   assign PC_curr   = pc;
   assign PC_next   = pc + 16'd2;
   assign PC_inst   = imem_rdata;
   assign halt      = (imem_rdata[15:12] == 4'hF);

`ifdef BRANCH_PREDICT_EN
   localparam int IDX = $clog2(BTB_ENTRIES);

   logic [1:0]             cnt    [BTB_ENTRIES];
   logic [15:0]            target [BTB_ENTRIES];
   logic [BTB_ENTRIES-1:0] valid;
   logic [IDX-1:0]         idx;
   logic [IDX-1:0]         uidx;

   assign idx              = pc[IDX:1];
   assign uidx             = upd_PC_curr[IDX:1];
   assign predicted_taken  = valid[idx] & cnt[idx][1];
   assign predicted_target = target[idx];

   // Lookup reads the array before this edge's update lands: no bypass on same-index collisions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            cnt[i]    <= CNT_INIT;
            target[i] <= 16'h0000;
         end
      end else if (upd_en) begin
         if (upd_taken) begin
            if (cnt[uidx] != 2'b11) cnt[uidx] <= cnt[uidx] + 2'd1;
            target[uidx] <= upd_target;
            valid[uidx]  <= 1'b1;
         end else if (cnt[uidx] != 2'b00) begin
            cnt[uidx] <= cnt[uidx] - 2'd1;
         end
      end
   end

   wire unused_upd_pc = ^upd_PC_curr;
`else
   assign predicted_taken  = 1'b0;
   assign predicted_target = 16'h0000;

   wire unused_cfg = ^{upd_en, upd_PC_curr, upd_taken, upd_target, CNT_INIT, BTB_ENTRIES[0]};
`endif

   always_comb begin
      pc_d = PC_next;
      if (mispredict)           pc_d = redirect_PC;
      else if (stall || halt)   pc_d = pc;
      else if (predicted_taken) pc_d = predicted_target;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= RESET_PC;
      else        pc <= pc_d;
   end

endmodule

// File: tb/tb_fetch_stage_bp.sv
// tb/tb_fetch_stage_bp.sv - table-driven bench for fetch_stage_bp (either BRANCH_PREDICT_EN build)
module tb_fetch_stage_bp;

`ifdef BRANCH_PREDICT_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, upd_en, upd_taken, mispredict;
   logic [15:0] imem_rdata, upd_target, redirect_PC;
   logic [3:0]  upd_PC_curr;
   logic [15:0] imem_addr, PC_curr, PC_next, PC_inst, predicted_target;
   logic        predicted_taken;

   int tests = 0;
   int fails = 0;

   fetch_stage_bp dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .imem_rdata(imem_rdata),
      .upd_en(upd_en), .upd_PC_curr(upd_PC_curr), .upd_taken(upd_taken),
      .upd_target(upd_target), .mispredict(mispredict), .redirect_PC(redirect_PC),
      .imem_addr(imem_addr), .PC_curr(PC_curr), .PC_next(PC_next), .PC_inst(PC_inst),
      .predicted_taken(predicted_taken), .predicted_target(predicted_target)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        misp;
      logic [15:0] redir;
      logic        upd_en;
      logic [3:0]  upd_pc;
      logic        upd_taken;
      logic [15:0] upd_tgt;
      logic [15:0] exp_pc_bp;
      logic [15:0] exp_pc_nb;
      logic        exp_pt_bp;
   } vec_t;

   vec_t vecs [19];

   function automatic vec_t mk(logic st, logic mp, logic [15:0] rd, logic ue, logic ut,
                               logic [15:0] pbp, logic [15:0] pnb, logic pt);
      vec_t v;
      v.stall = st; v.misp = mp; v.redir = rd;
      v.upd_en = ue; v.upd_pc = 4'h6; v.upd_taken = ut; v.upd_tgt = 16'h0040;
      v.exp_pc_bp = pbp; v.exp_pc_nb = pnb; v.exp_pt_bp = pt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_pc(input string name, input logic [15:0] exp);
      chk({name, ".PC_curr"}, PC_curr, exp);
      chk({name, ".imem_addr"}, imem_addr, exp);
      chk({name, ".PC_next"}, PC_next, exp + 16'd2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // stall, misp, redir, upd_en, upd_taken, exp PC (bp build), exp PC (no-bp build), exp taken
      vecs[0]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
      vecs[1]  = mk(0, 0, 16'h0000, 0, 0, 16'h0002, 16'h0002, 0);
      vecs[2]  = mk(1, 0, 16'h0000, 1, 1, 16'h0004, 16'h0004, 0);
      vecs[3]  = mk(1, 0, 16'h0000, 1, 1, 16'h0004, 16'h0004, 0);
      vecs[4]  = mk(0, 0, 16'h0000, 0, 0, 16'h0004, 16'h0004, 0);
      vecs[5]  = mk(0, 0, 16'h0000, 0, 0, 16'h0006, 16'h0006, 1);
      vecs[6]  = mk(0, 0, 16'h0000, 0, 0, 16'h0040, 16'h0008, 0);
      vecs[7]  = mk(0, 1, 16'h0006, 0, 0, 16'h0042, 16'h000A, 0);
      vecs[8]  = mk(1, 0, 16'h0000, 1, 0, 16'h0006, 16'h0006, 1);
      vecs[9]  = mk(1, 0, 16'h0000, 1, 0, 16'h0006, 16'h0006, 1);
      vecs[10] = mk(1, 0, 16'h0000, 1, 0, 16'h0006, 16'h0006, 0);
      vecs[11] = mk(1, 0, 16'h0000, 1, 0, 16'h0006, 16'h0006, 0);
      vecs[12] = mk(0, 0, 16'h0000, 0, 0, 16'h0006, 16'h0006, 0);
      vecs[13] = mk(1, 1, 16'h1234, 0, 0, 16'h0008, 16'h0008, 0);
      vecs[14] = mk(1, 0, 16'h0000, 0, 0, 16'h1234, 16'h1234, 0);
      vecs[15] = mk(1, 0, 16'h0000, 0, 0, 16'h1234, 16'h1234, 0);
      vecs[16] = mk(1, 0, 16'h0000, 0, 0, 16'h1234, 16'h1234, 0);
      vecs[17] = mk(0, 0, 16'h0000, 0, 0, 16'h1234, 16'h1234, 0);
      vecs[18] = mk(0, 0, 16'h0000, 0, 0, 16'h1236, 16'h1236, 0);

      rst_n = 1'b0; stall = 0; mispredict = 0; redirect_PC = 0; imem_rdata = 16'h0000;
      upd_en = 0; upd_PC_curr = 0; upd_taken = 0; upd_target = 0;
      repeat (2) @(negedge clk);
      #1;
      chk_pc("reset", 16'h0000);
      chk("reset.pt", {15'd0, predicted_taken}, 16'h0000);
      chk("reset.PC_inst", PC_inst, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         stall = vecs[i].stall; mispredict = vecs[i].misp; redirect_PC = vecs[i].redir;
         upd_en = vecs[i].upd_en; upd_PC_curr = vecs[i].upd_pc;
         upd_taken = vecs[i].upd_taken; upd_target = vecs[i].upd_tgt;
         #1;
         chk_pc($sformatf("vec%0d", i), BP ? vecs[i].exp_pc_bp : vecs[i].exp_pc_nb);
         chk($sformatf("vec%0d.pt", i), {15'd0, predicted_taken},
             {15'd0, BP & vecs[i].exp_pt_bp});
         @(negedge clk);
      end
      stall = 0; mispredict = 0; upd_en = 0;

      // halt holds PC; only a mispredict releases it
      mispredict = 1; redirect_PC = 16'h0010;
      @(negedge clk);
      mispredict = 0; imem_rdata = 16'hF000;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk_pc($sformatf("hlt%0d", i), 16'h0010);
         chk("hlt.PC_inst", PC_inst, 16'hF000);
         @(negedge clk);
      end
      mispredict = 1; redirect_PC = 16'h0020;
      @(negedge clk);
      mispredict = 0; imem_rdata = 16'h0000;
      #1;
      chk_pc("hlt_exit", 16'h0020);

      // wrap at top of address space
      @(negedge clk);
      mispredict = 1; redirect_PC = 16'hFFFE;
      @(negedge clk);
      mispredict = 0;
      #1;
      chk("wrap.PC_curr", PC_curr, 16'hFFFE);
      chk("wrap.PC_next", PC_next, 16'h0000);
      @(negedge clk);
      #1;
      chk("wrap.after", PC_curr, 16'h0000);

      // asynchronous reset mid-cycle
      @(negedge clk);
      #1;
      chk("prerst.PC", PC_curr, 16'h0002);
      #2;
      rst_n = 1'b0;
      #1;
      chk("asyncrst.PC", PC_curr, 16'h0000);
      chk("asyncrst.pt", {15'd0, predicted_taken}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk_pc($sformatf("postrst%0d", i), 16'(2 * i));
         @(negedge clk);
      end

      // same-cycle lookup/update of index 3: no bypass, visible next cycle
      mispredict = 1; redirect_PC = 16'h0016;
      @(negedge clk);
      mispredict = 0; stall = 1;
      upd_en = 1; upd_PC_curr = 4'h6; upd_taken = 1; upd_target = 16'h0100;
      #1;
      chk_pc("alias0", 16'h0016);
      chk("alias0.pt", {15'd0, predicted_taken}, 16'h0000);
      @(negedge clk);
      upd_en = 0;
      #1;
      chk_pc("alias1", 16'h0016);
      chk("alias1.pt", {15'd0, predicted_taken}, {15'd0, BP});
      chk("alias1.tgt", predicted_target, BP ? 16'h0100 : 16'h0000);
      @(negedge clk);
      stall = 0;
      @(negedge clk);
      #1;
      chk_pc("alias2", BP ? 16'h0100 : 16'h0018);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
